// File: rtl/tt_pad_pkg.sv
// Shared types and parked-pad values for the pad-side sequencer.
package tt_pad_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    IN       = 3'd1,
    TURN_OUT = 3'd2,
    OUT      = 3'd3,
    TURN_IN  = 3'd4
  } pad_state_t;

  localparam logic PAD_PARK_A  = 1'b0;
  localparam logic PAD_PARK_OE = 1'b0;
  localparam logic PAD_PARK_IE = 1'b0;
  localparam logic PAD_PARK_SL = 1'b0;
  localparam logic PAD_PARK_CS = 1'b0;
  localparam logic PAD_PARK_PD = 1'b1;
  localparam logic PAD_PARK_PU = 1'b0;

  // Returns {pd, pu}. A conflicting request releases both pulls.
  function automatic logic [1:0] pull_resolve(input logic pd, input logic pu);
    return {pd & ~pu, pu & ~pd};
  endfunction

endpackage

// File: rtl/tt_pad_in_filter.sv
// Pad input synchroniser followed by a consecutive-sample glitch filter.
module tt_pad_in_filter
  import tt_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d_async,
  output logic q
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   sample;

  assign sample = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      q    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_async};
      if (clr) begin
        cnt <= '0;
        q   <= 1'b0;
      end else if (sample == q) begin
        cnt <= '0;
      end else if (cnt >= CW'(FILT_LEN - 1)) begin
        // FILT_LEN-th consecutive differing sample: accept it.
        q   <= sample;
        cnt <= CW'(FILT_LEN);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/tt_pad_seq.sv
// Pad-side sequencer: direction turnaround FSM, pull legalisation and
// filtered input return path for one bidirectional pad.
module tt_pad_seq
  import tt_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int TURN_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cell_A,
  input  logic cell_OE,
  input  logic cell_IE,
  input  logic cell_SL,
  input  logic cell_CS,
  input  logic cell_PD,
  input  logic cell_PU,
  output logic cell_Y,
  output logic pad_A,
  output logic pad_OE,
  output logic pad_IE,
  output logic pad_SL,
  output logic pad_CS,
  output logic pad_PD,
  output logic pad_PU,
  input  logic pad_Y,
  output logic turn,
  output logic pull_err
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);

  pad_state_t    state, nxt;
  logic [TW-1:0] cnt;
  logic          ie_nxt;
  logic [1:0]    pull;

  always_comb begin
    nxt = state;
    unique case (state)
      OFF:      if (en) nxt = IN;
      IN:       if (cell_OE) nxt = TURN_OUT;
      TURN_OUT: if (!cell_OE) nxt = IN;
                else if (cnt == '0) nxt = OUT;
      OUT:      if (!cell_OE) nxt = TURN_IN;
      TURN_IN:  if (cnt == '0) nxt = IN;
      default:  nxt = OFF;
    endcase
    if (!en) nxt = OFF;
  end

  // Filter is cleared on the same edge pad_IE falls, so cell_Y drops with it.
  assign ie_nxt = (nxt != OFF) & cell_IE;
  assign pull   = pull_resolve(cell_PD, cell_PU);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      cnt      <= '0;
      pad_A    <= PAD_PARK_A;
      pad_OE   <= PAD_PARK_OE;
      pad_IE   <= PAD_PARK_IE;
      pad_SL   <= PAD_PARK_SL;
      pad_CS   <= PAD_PARK_CS;
      pad_PD   <= PAD_PARK_PD;
      pad_PU   <= PAD_PARK_PU;
      turn     <= 1'b0;
      pull_err <= 1'b0;
    end else begin
      state <= nxt;

      if ((state == IN && nxt == TURN_OUT) || (state == OUT && nxt == TURN_IN))
        cnt <= TURN_LOAD;
      else if (nxt == OFF || nxt == IN || nxt == OUT)
        cnt <= '0;
      else if (cnt != '0)
        cnt <= cnt - TW'(1);

      if (nxt == OFF) begin
        pad_A  <= PAD_PARK_A;
        pad_OE <= PAD_PARK_OE;
        pad_IE <= PAD_PARK_IE;
        pad_SL <= PAD_PARK_SL;
        pad_CS <= PAD_PARK_CS;
        pad_PD <= PAD_PARK_PD;
        pad_PU <= PAD_PARK_PU;
        turn   <= 1'b0;
      end else begin
        pad_OE <= (nxt == OUT);
        turn   <= (nxt == TURN_OUT) || (nxt == TURN_IN);
        pad_IE <= cell_IE;
        pad_SL <= cell_SL;
        pad_CS <= cell_CS;
        {pad_PD, pad_PU} <= pull;
        if (cell_PD && cell_PU) pull_err <= 1'b1;
        // Data is frozen on the OE-rise edge so the driver starts on the pre-loaded value.
        if (nxt == TURN_OUT || (nxt == OUT && state == OUT))
          pad_A <= cell_A;
      end
    end
  end

  tt_pad_in_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_in_filter (
    .clk    (clk),
    .rst    (rst),
    .clr    (~ie_nxt),
    .d_async(pad_Y),
    .q      (cell_Y)
  );

endmodule

// File: tb/tb_tt_pad_seq.sv
// Directed bench for tt_pad_seq plus a randomised turnaround-safety monitor.
module tb_tt_pad_seq;

  logic clk = 1'b0;
  logic rst, en, cell_A, cell_OE, cell_IE, cell_SL, cell_CS, cell_PD, cell_PU, pad_Y;
  logic cell_Y, pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU, turn, pull_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_pad_seq dut (
    .clk(clk), .rst(rst), .en(en),
    .cell_A(cell_A), .cell_OE(cell_OE), .cell_IE(cell_IE), .cell_SL(cell_SL),
    .cell_CS(cell_CS), .cell_PD(cell_PD), .cell_PU(cell_PU), .cell_Y(cell_Y),
    .pad_A(pad_A), .pad_OE(pad_OE), .pad_IE(pad_IE), .pad_SL(pad_SL),
    .pad_CS(pad_CS), .pad_PD(pad_PD), .pad_PU(pad_PU), .pad_Y(pad_Y),
    .turn(turn), .pull_err(pull_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // OE must rise only after TURN_CYCLES low cycles, with pad_A unchanged at the rise.
  logic prev_oe = 1'b0;
  logic prev_a  = 1'b0;
  int   low_cnt = 0;
  always @(negedge clk) begin
    if (pad_OE && !prev_oe) begin
      chk("oe_gap", 32'(low_cnt >= 2), 32'd1);
      chk("oe_a_stable", 32'(pad_A), 32'(prev_a));
    end
    low_cnt = pad_OE ? 0 : ((low_cnt < 1000) ? low_cnt + 1 : low_cnt);
    prev_oe = pad_OE;
    prev_a  = pad_A;
  end

  initial begin
    logic seen;
    rst = 1; en = 1; cell_A = 1; cell_OE = 1; cell_IE = 1; cell_SL = 0; cell_CS = 0;
    cell_PD = 0; cell_PU = 0; pad_Y = 0;
    tick(3);
    chk("rst_outs", 32'({pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU, cell_Y, turn, pull_err}),
        32'b0000010000);

    // Power-up turnaround: OFF -> IN -> TURN_OUT x2 -> OUT
    rst = 0;
    tick(); chk("in_turn", turn, 0); chk("in_oe", pad_OE, 0); chk("in_pd", pad_PD, 0); chk("in_ie", pad_IE, 1);
    tick(); chk("to1_turn", turn, 1); chk("to1_oe", pad_OE, 0); chk("to1_a", pad_A, 1);
    tick(); chk("to2_turn", turn, 1); chk("to2_oe", pad_OE, 0);
    tick(); chk("out_oe", pad_OE, 1); chk("out_turn", turn, 0); chk("out_a", pad_A, 1);
    cell_A = 0; tick(); chk("out_a0", pad_A, 0);
    cell_A = 1; tick(); chk("out_a1", pad_A, 1);

    // Out -> in turnaround with OE re-request ignored mid-turn
    cell_OE = 0;
    tick(); chk("ti1_oe", pad_OE, 0); chk("ti1_turn", turn, 1);
    tick(); chk("ti2_turn", turn, 1);
    cell_OE = 1;
    tick(); chk("ti_in_turn", turn, 0); chk("ti_in_oe", pad_OE, 0);
    tick(); chk("re_to1", turn, 1); chk("re_to1_oe", pad_OE, 0);
    tick(); chk("re_to2", turn, 1); chk("re_to2_oe", pad_OE, 0);
    tick(); chk("re_out_oe", pad_OE, 1);
    cell_OE = 0;
    tick(3); chk("back_in", turn, 0);

    // Input filter: step latency and pulse rejection
    pad_Y = 1;
    tick(4); chk("step_4", cell_Y, 0);
    tick();  chk("step_5", cell_Y, 1);
    pad_Y = 0;
    tick(4); chk("fall_4", cell_Y, 1);
    tick();  chk("fall_5", cell_Y, 0);
    pad_Y = 1; tick(2); pad_Y = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); seen |= cell_Y; end
    chk("pulse2_rej", seen, 0);
    pad_Y = 1; tick(3); pad_Y = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); seen |= cell_Y; end
    chk("pulse3_pass", seen, 1);
    tick(6); chk("pulse3_end", cell_Y, 0);

    // Pulls and pass-through
    cell_PD = 1; cell_PU = 1;
    tick(); chk("pull_both", 32'({pad_PD, pad_PU, pull_err}), 32'b001);
    cell_PU = 0;
    tick(); chk("pull_pd", 32'({pad_PD, pad_PU, pull_err}), 32'b101);
    cell_PD = 0; cell_PU = 1;
    tick(); chk("pull_pu", 32'({pad_PD, pad_PU}), 32'b01);
    cell_PU = 0; cell_SL = 1; cell_CS = 1;
    tick(); chk("sl_cs", 32'({pad_SL, pad_CS}), 32'b11);

    // Global disable while driving
    pad_Y = 1; cell_OE = 1;
    tick(6); chk("pre_off_oe", pad_OE, 1); chk("pre_off_y", cell_Y, 1);
    en = 0;
    tick();
    chk("off_outs", 32'({pad_OE, pad_PD, pad_PU, pad_IE, pad_SL, pad_CS, cell_Y, turn, pad_A}), 32'b010000000);
    chk("off_perr", pull_err, 1);
    en = 1;
    tick(); chk("reen_in", turn, 0);
    tick(); chk("reen_to", turn, 1);
    cell_OE = 0;
    tick(); chk("abort_to", turn, 0); chk("abort_oe", pad_OE, 0);

    // Random stress; the negedge monitor checks every OE rise
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 5) == 0) cell_OE = ~cell_OE;
      cell_A  = 1'($urandom);
      cell_IE = ($urandom_range(0, 7) != 0);
      cell_PD = 1'($urandom);
      cell_PU = 1'($urandom);
      cell_SL = 1'($urandom);
      cell_CS = 1'($urandom);
      pad_Y   = 1'($urandom);
      tick();
      if (pad_OE) chk("stress_oe_state", turn, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
